// File: rtl/ifu_fetch.sv
// Instruction fetch unit: one AXI4-Lite read per instruction, handed to decode through the IF/ID write enable.
// Optional response checking is enabled with `define IFU_RRESP_CHECK_EN (halts on an error response).
//
// state | meaning
// IDLE  | one-cycle start after reset; fetch begins at pc next cycle
// AR    | read address presented at pc, waiting for arready_i
// R     | waiting for read data; discards it if a redirect is pending
// HOLD  | instruction held for decode; we_o follows idu_ready_i
// HALT  | error response seen; waits for a redirect
module ifu_fetch #(
   parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
   input  logic        clk,
   input  logic        rst,
   output logic        arvalid_o,
   input  logic        arready_i,
   output logic [31:0] araddr_o,
   input  logic        rvalid_i,
   output logic        rready_o,
   input  logic [31:0] rdata_i,
   input  logic [1:0]  rresp_i,
   input  logic        idu_ready_i,
   output logic        we_o,
   output logic [31:0] inst_addr_o,
   output logic [31:0] inst_o,
   input  logic        redirect_i,
   input  logic [31:0] redirect_pc_i,
   output logic        fault_o
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_AR,
      S_R,
      S_HOLD,
      S_HALT
   } state_t;

   state_t      state;
   logic [31:0] pc;
   logic        redir_pend;
   logic [31:0] redir_pc;
   logic [31:0] inst_q;
   logic [31:0] inst_addr_q;
   logic        resp_err;

`ifdef IFU_RRESP_CHECK_EN
   assign resp_err = (rresp_i != 2'b00);
   assign fault_o  = (state == S_HALT);
`else
   logic unused_rresp;
   assign unused_rresp = ^rresp_i;
   assign resp_err     = 1'b0;
   assign fault_o      = 1'b0;
`endif

   assign arvalid_o   = (state == S_AR);
   assign rready_o    = (state == S_R);
   assign araddr_o    = pc;
   assign inst_o      = inst_q;
   assign inst_addr_o = inst_addr_q;
   // A redirect in HOLD drops the held instruction even if decode is ready.
   assign we_o        = (state == S_HOLD) && idu_ready_i && !redirect_i;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= S_IDLE;
         pc          <= RESET_PC;
         redir_pend  <= 1'b0;
         redir_pc    <= '0;
         inst_q      <= '0;
         inst_addr_q <= '0;
      end else begin
         unique case (state)
            S_IDLE: begin
               state <= S_AR;
               if (redirect_i) pc <= redirect_pc_i;
            end
            S_AR: begin
               // pc stays put until the address is accepted; redirects wait.
               if (redirect_i) begin
                  redir_pend <= 1'b1;
                  redir_pc   <= redirect_pc_i;
               end
               if (arready_i) state <= S_R;
            end
            S_R: begin
               if (rvalid_i) begin
                  if (redirect_i || redir_pend) begin
                     pc         <= redirect_i ? redirect_pc_i : redir_pc;
                     redir_pend <= 1'b0;
                     state      <= S_AR;
                  end else if (resp_err) begin
                     inst_addr_q <= pc;
                     state       <= S_HALT;
                  end else begin
                     inst_q      <= rdata_i;
                     inst_addr_q <= pc;
                     state       <= S_HOLD;
                  end
               end else if (redirect_i) begin
                  redir_pend <= 1'b1;
                  redir_pc   <= redirect_pc_i;
               end
            end
            S_HOLD: begin
               if (redirect_i) begin
                  pc    <= redirect_pc_i;
                  state <= S_AR;
               end else if (idu_ready_i) begin
                  pc    <= pc + 32'd4;
                  state <= S_AR;
               end
            end
            S_HALT: begin
               if (redirect_i) begin
                  pc    <= redirect_pc_i;
                  state <= S_AR;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ifu_fetch.sv
// Self-checking bench for ifu_fetch: scripted AXI slave, scoreboard of expected
// deliveries popped whenever we_o fires.
module tb_ifu_fetch;

   logic        clk = 1'b0;
   logic        rst;
   logic        arvalid_o, arready_i, rvalid_i, rready_o, idu_ready_i, we_o;
   logic        redirect_i, fault_o;
   logic [31:0] araddr_o, rdata_i, inst_addr_o, inst_o, redirect_pc_i;
   logic [1:0]  rresp_i;

   int n_checks = 0;
   int n_fail   = 0;
   int we_cnt   = 0;
   logic [63:0] exp_q[$];

   ifu_fetch dut (
      .clk(clk), .rst(rst),
      .arvalid_o(arvalid_o), .arready_i(arready_i), .araddr_o(araddr_o),
      .rvalid_i(rvalid_i), .rready_o(rready_o), .rdata_i(rdata_i), .rresp_i(rresp_i),
      .idu_ready_i(idu_ready_i), .we_o(we_o), .inst_addr_o(inst_addr_o), .inst_o(inst_o),
      .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i), .fault_o(fault_o)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      logic [63:0] e;
      n_checks++;
      if (arvalid_o && rready_o) begin
         n_fail++;
         $display("FAIL one_outstanding: arvalid_o=1 and rready_o=1 together, required not both");
      end
      if (we_o) begin
         we_cnt++;
         n_checks++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_we: we_o=1 addr=%h inst=%h, required no delivery", inst_addr_o, inst_o);
         end else begin
            e = exp_q.pop_front();
            if ({inst_addr_o, inst_o} !== e) begin
               n_fail++;
               $display("FAIL delivery: got addr=%h inst=%h, required addr=%h inst=%h",
                        inst_addr_o, inst_o, e[63:32], e[31:0]);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b0; arready_i = 1'b1; rvalid_i = 1'b1; idu_ready_i = 1'b1;
      rdata_i = 32'h0; rresp_i = 2'b00; redirect_i = 1'b0; redirect_pc_i = 32'h0;
      repeat (3) tick();
      n_checks++;
      if ({arvalid_o, rready_o, we_o, fault_o} !== 4'b0000) begin
         n_fail++;
         $display("FAIL reset_ctrl: got %b, required 0000", {arvalid_o, rready_o, we_o, fault_o});
      end
      n_checks++;
      if ({araddr_o, inst_o, inst_addr_o} !== {32'h8000_0000, 32'h0, 32'h0}) begin
         n_fail++;
         $display("FAIL reset_data: araddr=%h inst=%h inst_addr=%h, required 80000000 0 0",
                  araddr_o, inst_o, inst_addr_o);
      end
      rst = 1'b1;
   endtask

   task automatic test_stream();
      logic [31:0] exp_addr [3];
      int at [3];
      int k = 0;
      exp_addr[0] = 32'h8000_0000; exp_addr[1] = 32'h8000_0004; exp_addr[2] = 32'h8000_0008;
      arready_i = 1'b1; rvalid_i = 1'b1; idu_ready_i = 1'b1; rdata_i = 32'h0000_0013;
      for (int c = 0; c < 20 && k < 3; c++) begin
         if (arvalid_o) begin
            n_checks++;
            if (araddr_o !== exp_addr[k]) begin
               n_fail++;
               $display("FAIL stream_addr%0d: got %h, required %h", k, araddr_o, exp_addr[k]);
            end
            exp_q.push_back({exp_addr[k], 32'h0000_0013});
            at[k] = c;
            k++;
         end
         if (k < 3) tick();
      end
      n_checks++;
      if (k != 3) begin
         n_fail++;
         $display("FAIL stream_timeout: saw %0d fetches, required 3", k);
      end else begin
         n_checks++;
         if (at[1] - at[0] != 3 || at[2] - at[1] != 3) begin
            n_fail++;
            $display("FAIL stream_rate: gaps %0d %0d, required 3 3", at[1] - at[0], at[2] - at[1]);
         end
      end
      tick();
      arready_i = 1'b0;
      tick();
      tick();
      n_checks++;
      if (we_cnt != 3 || exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL stream_we_count: got %0d pending %0d, required 3 pending 0", we_cnt, exp_q.size());
      end
   endtask

   task automatic test_ar_stall();
      rvalid_i = 1'b0;
      for (int i = 0; i < 5; i++) begin
         n_checks++;
         if (arvalid_o !== 1'b1 || araddr_o !== 32'h8000_000C) begin
            n_fail++;
            $display("FAIL ar_stall%0d: arvalid=%b araddr=%h, required 1 8000000c", i, arvalid_o, araddr_o);
         end
         if (i == 2) begin redirect_i = 1'b1; redirect_pc_i = 32'h8000_0200; end
         tick();
         redirect_i = 1'b0;
      end
      arready_i = 1'b1;
      #1;
      n_checks++;
      if (araddr_o !== 32'h8000_000C) begin
         n_fail++;
         $display("FAIL ar_stall_hs: got %h, required 8000000c", araddr_o);
      end
      tick();
      arready_i = 1'b0; rvalid_i = 1'b1; rdata_i = 32'hDEAD_0000;
      tick();
      rvalid_i = 1'b0;
      #1;
      n_checks++;
      if (arvalid_o !== 1'b1 || araddr_o !== 32'h8000_0200 || we_cnt != 3) begin
         n_fail++;
         $display("FAIL ar_stall_redirect: arvalid=%b araddr=%h we_cnt=%0d, required 1 80000200 3",
                  arvalid_o, araddr_o, we_cnt);
      end
   endtask

   task automatic test_hold_stall();
      arready_i = 1'b1;
      tick();
      arready_i = 1'b0; rvalid_i = 1'b1; rdata_i = 32'hCAFE_0001; idu_ready_i = 1'b0;
      exp_q.push_back({32'h8000_0200, 32'hCAFE_0001});
      tick();
      rvalid_i = 1'b0;
      for (int i = 0; i < 4; i++) begin
         #1;
         n_checks++;
         if (we_o !== 1'b0 || arvalid_o !== 1'b0 || inst_o !== 32'hCAFE_0001) begin
            n_fail++;
            $display("FAIL hold_stall%0d: we=%b arvalid=%b inst=%h, required 0 0 cafe0001",
                     i, we_o, arvalid_o, inst_o);
         end
         tick();
      end
      idu_ready_i = 1'b1;
      #1;
      n_checks++;
      if (we_o !== 1'b1) begin
         n_fail++;
         $display("FAIL hold_release: we=%b, required 1", we_o);
      end
      tick();
      n_checks++;
      if (araddr_o !== 32'h8000_0204 || we_cnt != 4) begin
         n_fail++;
         $display("FAIL hold_next: araddr=%h we_cnt=%0d, required 80000204 4", araddr_o, we_cnt);
      end
   endtask

   task automatic test_redirect();
      arready_i = 1'b1;
      tick();
      arready_i = 1'b0; redirect_i = 1'b1; redirect_pc_i = 32'h8000_0100;
      tick();
      redirect_i = 1'b0; rvalid_i = 1'b1; rdata_i = 32'hBAD0_0001;
      tick();
      rvalid_i = 1'b0;
      #1;
      n_checks++;
      if (araddr_o !== 32'h8000_0100 || arvalid_o !== 1'b1 || we_cnt != 4 || inst_o !== 32'hCAFE_0001) begin
         n_fail++;
         $display("FAIL redirect_in_r: araddr=%h arvalid=%b we_cnt=%0d inst=%h, required 80000100 1 4 cafe0001",
                  araddr_o, arvalid_o, we_cnt, inst_o);
      end
      arready_i = 1'b1;
      tick();
      arready_i = 1'b0; redirect_i = 1'b1; redirect_pc_i = 32'h8000_0300;
      rvalid_i = 1'b1; rdata_i = 32'hBAD0_0002;
      tick();
      redirect_i = 1'b0; rvalid_i = 1'b0;
      #1;
      n_checks++;
      if (araddr_o !== 32'h8000_0300 || we_cnt != 4) begin
         n_fail++;
         $display("FAIL redirect_with_rvalid: araddr=%h we_cnt=%0d, required 80000300 4", araddr_o, we_cnt);
      end
      redirect_i = 1'b1; redirect_pc_i = 32'h8000_0400;
      tick();
      redirect_pc_i = 32'h8000_0500;
      tick();
      redirect_i = 1'b0;
      n_checks++;
      if (araddr_o !== 32'h8000_0300) begin
         n_fail++;
         $display("FAIL redirect_ar_stable: got %h, required 80000300", araddr_o);
      end
      arready_i = 1'b1;
      tick();
      arready_i = 1'b0; rvalid_i = 1'b1; rdata_i = 32'hBAD0_0003;
      tick();
      rvalid_i = 1'b0;
      #1;
      n_checks++;
      if (araddr_o !== 32'h8000_0500 || we_cnt != 4) begin
         n_fail++;
         $display("FAIL redirect_latest: araddr=%h we_cnt=%0d, required 80000500 4", araddr_o, we_cnt);
      end
   endtask

   task automatic test_hold_redirect_wrap();
      arready_i = 1'b1;
      tick();
      arready_i = 1'b0; rvalid_i = 1'b1; rdata_i = 32'hBAD0_0004; idu_ready_i = 1'b0;
      tick();
      rvalid_i = 1'b0; idu_ready_i = 1'b1; redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFFC;
      #1;
      n_checks++;
      if (we_o !== 1'b0) begin
         n_fail++;
         $display("FAIL hold_redirect_we: got %b, required 0", we_o);
      end
      tick();
      redirect_i = 1'b0;
      n_checks++;
      if (araddr_o !== 32'hFFFF_FFFC || arvalid_o !== 1'b1) begin
         n_fail++;
         $display("FAIL hold_redirect_pc: araddr=%h arvalid=%b, required fffffffc 1", araddr_o, arvalid_o);
      end
      arready_i = 1'b1;
      tick();
      arready_i = 1'b0; rvalid_i = 1'b1; rdata_i = 32'h1234_5678;
      exp_q.push_back({32'hFFFF_FFFC, 32'h1234_5678});
      tick();
      rvalid_i = 1'b0;
      tick();
      n_checks++;
      if (araddr_o !== 32'h0000_0000 || we_cnt != 5) begin
         n_fail++;
         $display("FAIL pc_wrap: araddr=%h we_cnt=%0d, required 00000000 5", araddr_o, we_cnt);
      end
   endtask

   task automatic test_rresp();
      arready_i = 1'b1;
      tick();
      arready_i = 1'b0; rvalid_i = 1'b1; rresp_i = 2'b10; rdata_i = 32'hABCD_0008;
`ifndef IFU_RRESP_CHECK_EN
      exp_q.push_back({32'h0000_0000, 32'hABCD_0008});
`endif
      tick();
      rvalid_i = 1'b0; rresp_i = 2'b00;
      #1;
`ifdef IFU_RRESP_CHECK_EN
      for (int i = 0; i < 2; i++) begin
         n_checks++;
         if (fault_o !== 1'b1 || inst_addr_o !== 32'h0 || we_o !== 1'b0 || arvalid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL rresp_halt%0d: fault=%b inst_addr=%h we=%b arvalid=%b, required 1 0 0 0",
                     i, fault_o, inst_addr_o, we_o, arvalid_o);
         end
         tick();
      end
      redirect_i = 1'b1; redirect_pc_i = 32'h8000_0000;
      tick();
      redirect_i = 1'b0;
      n_checks++;
      if (fault_o !== 1'b0 || araddr_o !== 32'h8000_0000 || arvalid_o !== 1'b1) begin
         n_fail++;
         $display("FAIL rresp_resume: fault=%b araddr=%h arvalid=%b, required 0 80000000 1",
                  fault_o, araddr_o, arvalid_o);
      end
`else
      n_checks++;
      if (fault_o !== 1'b0 || we_o !== 1'b1) begin
         n_fail++;
         $display("FAIL rresp_ignored: fault=%b we=%b, required 0 1", fault_o, we_o);
      end
      tick();
      n_checks++;
      if (araddr_o !== 32'h0000_0004 || arvalid_o !== 1'b1) begin
         n_fail++;
         $display("FAIL rresp_next: araddr=%h arvalid=%b, required 00000004 1", araddr_o, arvalid_o);
      end
`endif
   endtask

   task automatic test_reset_mid();
      int we_before;
      arready_i = 1'b1;
      tick();
      arready_i = 1'b0; rvalid_i = 1'b1; rdata_i = 32'h5555_AAAA;
      #1;
      rst = 1'b0;
      #1;
      n_checks++;
      if ({arvalid_o, rready_o, we_o, fault_o} !== 4'b0000 ||
          {araddr_o, inst_o, inst_addr_o} !== {32'h8000_0000, 32'h0, 32'h0}) begin
         n_fail++;
         $display("FAIL reset_mid: ctrl=%b araddr=%h inst=%h inst_addr=%h, required 0000 80000000 0 0",
                  {arvalid_o, rready_o, we_o, fault_o}, araddr_o, inst_o, inst_addr_o);
      end
      tick();
      tick();
      rst = 1'b1;
      we_before = we_cnt;
      tick();
      n_checks++;
      if (arvalid_o !== 1'b1 || araddr_o !== 32'h8000_0000 || rready_o !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_restart: arvalid=%b araddr=%h rready=%b, required 1 80000000 0",
                  arvalid_o, araddr_o, rready_o);
      end
      tick();
      n_checks++;
      if (arvalid_o !== 1'b1 || rready_o !== 1'b0 || we_cnt != we_before) begin
         n_fail++;
         $display("FAIL stale_rvalid: arvalid=%b rready=%b we_cnt=%0d, required 1 0 %0d",
                  arvalid_o, rready_o, we_cnt, we_before);
      end
      arready_i = 1'b1;
      tick();
      arready_i = 1'b0; rdata_i = 32'h0000_0077;
      exp_q.push_back({32'h8000_0000, 32'h0000_0077});
      tick();
      rvalid_i = 1'b0;
      tick();
      n_checks++;
      if (exp_q.size() != 0 || we_cnt != we_before + 1) begin
         n_fail++;
         $display("FAIL reset_first_fetch: pending=%0d we_cnt=%0d, required 0 %0d",
                  exp_q.size(), we_cnt, we_before + 1);
      end
   endtask

   initial begin
      test_reset();
      test_stream();
      test_ar_stall();
      test_hold_stall();
      test_redirect();
      test_hold_redirect_wrap();
      test_rresp();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
